// File: rtl/pulse_sequencer.sv
// pulse_sequencer: pops {delay, addr} descriptors, waits delay cycles, then streams a
// length-prefixed waveform from synchronous pulse memory one sample per cycle.
module pulse_sequencer #(
  parameter int DELAY_W = 32,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               fifo_empty,
  input  logic [DELAY_W-1:0] fifo_delay,
  input  logic [ADDR_W-1:0]  fifo_addr,
  output logic               fifo_rd_en,
  output logic               pmem_en,
  output logic [ADDR_W-1:0]  pmem_addr,
  input  logic [DATA_W-1:0]  pmem_rdata,
  output logic               sample_valid,
  output logic [DATA_W-1:0]  sample_data,
  output logic               pulse_start,
  output logic               pulse_done,
  output logic               busy
);
  typedef enum logic [2:0] {IDLE, DELAY, HDR_WAIT, STREAM, TAIL} state_t;
  state_t state, state_nx;
  logic [DELAY_W-1:0] cnt, cnt_nx;
  logic [ADDR_W-1:0] base, base_nx, addr, addr_nx;
  logic [LEN_W-1:0] rem, rem_nx, len;
  logic issue, start_nx;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      base <= '0;
      addr <= '0;
      rem <= '0;
      sample_valid <= 1'b0;
      pulse_start <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      base <= base_nx;
      addr <= addr_nx;
      rem <= rem_nx;
      sample_valid <= issue;
      pulse_start <= start_nx;
    end
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    base_nx = base;
    addr_nx = addr;
    rem_nx = rem;
    fifo_rd_en = 1'b0;
    pmem_en = 1'b0;
    pmem_addr = '0;
    pulse_done = 1'b0;
    issue = 1'b0;
    start_nx = 1'b0;
    len = pmem_rdata[LEN_W-1:0];
    case (state)
      IDLE:
        // reset_n gating keeps the pop strobe low while reset is held
        if (enable && !fifo_empty && reset_n) begin
          fifo_rd_en = 1'b1;
          cnt_nx = fifo_delay;
          base_nx = fifo_addr;
          state_nx = DELAY;
        end
      DELAY:
        if (cnt != '0) cnt_nx = cnt - DELAY_W'(1);
        else begin
          pmem_en = 1'b1;
          pmem_addr = base;
          state_nx = HDR_WAIT;
        end
      HDR_WAIT:
        if (len == '0) begin
          pulse_done = 1'b1;
          state_nx = IDLE;
        end else begin
          pmem_en = 1'b1;
          pmem_addr = base + ADDR_W'(1);
          issue = 1'b1;
          start_nx = 1'b1;
          rem_nx = len - LEN_W'(1);
          addr_nx = base + ADDR_W'(2);
          state_nx = (len == LEN_W'(1)) ? TAIL : STREAM;
        end
      STREAM: begin
        pmem_en = 1'b1;
        pmem_addr = addr;
        issue = 1'b1;
        addr_nx = addr + ADDR_W'(1);
        rem_nx = rem - LEN_W'(1);
        state_nx = (rem == LEN_W'(1)) ? TAIL : STREAM;
      end
      TAIL: begin
        pulse_done = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
  assign busy = state != IDLE;
  assign sample_data = sample_valid ? pmem_rdata : '0;
endmodule

// File: tb/tb_pulse_sequencer.sv
// tb_pulse_sequencer: randomized and directed stimulus checked every cycle against a
// timeline model derived from pop time, delay and waveform length.
module tb_pulse_sequencer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic fifo_empty;
  logic [31:0] fifo_delay;
  logic [9:0] fifo_addr;
  logic fifo_rd_en, pmem_en, sample_valid, pulse_start, pulse_done, busy;
  logic [9:0] pmem_addr;
  logic [31:0] pmem_rdata, sample_data;

  pulse_sequencer dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_delay(fifo_delay), .fifo_addr(fifo_addr), .fifo_rd_en(fifo_rd_en),
    .pmem_en(pmem_en), .pmem_addr(pmem_addr), .pmem_rdata(pmem_rdata),
    .sample_valid(sample_valid), .sample_data(sample_data), .pulse_start(pulse_start),
    .pulse_done(pulse_done), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [1024];
  logic [31:0] dq [128];
  logic [9:0] aq [128];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int n_cmp = 0;
  int n_err = 0;
  longint cyc = 0;

  always @(posedge clk) if (pmem_en) pmem_rdata <= mem[pmem_addr];
  always @(posedge clk) if (fifo_rd_en) rd_ptr <= rd_ptr + 1;
  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_delay = dq[rd_ptr % 128];
  assign fifo_addr = aq[rd_ptr % 128];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Model: a pulse is a timeline anchored at its pop cycle.
  logic act = 1'b0;
  longint pt, hdr, done;
  int pa, pl;
  always @(negedge clk) begin
    logic e_pop, e_busy, e_en, e_sv, e_ps, e_pd;
    logic [9:0] e_addr;
    logic [31:0] e_sd;
    cyc++;
    if (!reset_n) act = 1'b0;
    else if (act && cyc > done) act = 1'b0;
    e_pop = reset_n && !act && enable && !fifo_empty;
    if (e_pop) begin
      act = 1'b1;
      pt = cyc;
      hdr = cyc + 1 + longint'(dq[rd_ptr % 128]);
      pa = int'(aq[rd_ptr % 128]);
      pl = int'(mem[pa][15:0]);
      done = hdr + 1 + pl;
    end
    e_busy = act && cyc > pt;
    e_en = act && (cyc == hdr || (cyc > hdr && cyc <= hdr + pl));
    e_addr = e_en ? 10'(pa + int'(cyc - hdr)) : 10'd0;
    e_sv = act && cyc >= hdr + 2 && cyc <= hdr + 1 + pl;
    e_sd = e_sv ? mem[(pa + int'(cyc - hdr) - 1) & 1023] : 32'd0;
    e_ps = e_sv && cyc == hdr + 2;
    e_pd = act && cyc == done;
    check("fifo_rd_en", 64'(fifo_rd_en), 64'(e_pop));
    check("busy", 64'(busy), 64'(e_busy));
    check("pmem_en", 64'(pmem_en), 64'(e_en));
    check("pmem_addr", 64'(pmem_addr), 64'(e_addr));
    check("sample_valid", 64'(sample_valid), 64'(e_sv));
    check("sample_data", 64'(sample_data), 64'(e_sd));
    check("pulse_start", 64'(pulse_start), 64'(e_ps));
    check("pulse_done", 64'(pulse_done), 64'(e_pd));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [31:0] d, input logic [9:0] a);
    dq[wr_ptr % 128] = d;
    aq[wr_ptr % 128] = a;
    wr_ptr++;
  endtask

  task automatic wave(input int a, input int len);
    mem[a & 1023] = 32'(len);
    for (int k = 1; k <= len; k++) mem[(a + k) & 1023] = $urandom;
  endtask

  task automatic drain(input string tag, input logic rnd_en);
    logic drained = 1'b0;
    for (int i = 0; i < 5000 && !drained; i++) begin
      tick(1);
      if (rnd_en) enable = ($urandom % 4) != 0;
      drained = fifo_empty && !busy && !act;
    end
    check(tag, 64'(drained), 64'd1);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    tick(3);
    reset_n = 1'b1;
    tick(2);
    mem[16] = 4;
    mem[17] = 32'hA; mem[18] = 32'hB; mem[19] = 32'hC; mem[20] = 32'hD;
    push(3, 10'h010);
    enable = 1'b1;
    drain("drain_basic", 1'b0);
    mem[32] = 0;
    push(0, 10'h020);
    drain("drain_zero_len", 1'b0);
    wave(10'h3FE, 3);
    push(0, 10'h3FE);
    drain("drain_wrap", 1'b0);
    wave(48, 2);
    wave(64, 2);
    push(1, 10'h030);
    push(1, 10'h040);
    drain("drain_b2b", 1'b0);
    enable = 1'b0;
    wave(80, 5);
    wave(96, 3);
    push(1, 10'h050);
    push(0, 10'h060);
    tick(10);
    enable = 1'b1;
    tick(4);
    enable = 1'b0;
    tick(20);
    enable = 1'b1;
    drain("drain_enable", 1'b0);
    wave(112, 8);
    push(0, 10'h070);
    n = 0;
    for (int i = 0; i < 60 && n < 3; i++) begin
      @(negedge clk);
      if (sample_valid) n++;
    end
    check("rst_arm", 64'(n), 64'd3);
    tick(1);
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(5);
    for (int i = 0; i < 30; i++) begin
      int a = 256 + i * 24;
      wave(a, int'($urandom_range(0, 12)));
      push($urandom_range(0, 6), 10'(a));
    end
    drain("drain_random", 1'b1);
    enable = 1'b1;
    tick(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
